bitrev_ctrl: RTL

//  Stream-side sequencer for the bitreverse reorder core. Converts a

---
 rtl/bitrev_ctrl_pkg.sv | 12 +
 rtl/bitrev_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bitrev_ctrl_pkg.sv
// Shared definitions for the bit-reverse stage sequencer.
package bitrev_ctrl_pkg;

    // Sequencer states; the encoding is visible on o_state.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/bitrev_ctrl.sv
// Stream-side sequencer for the bit-reverse reorder core: turns a valid/ready
// sample stream with frame sync into core ce/reset/data, flushes the final
// frame with zeros, flags sync errors and tags the reordered output stream.
module bitrev_ctrl
    import bitrev_ctrl_pkg::*;
#(
    parameter int unsigned LGSIZE = 5,
    parameter int unsigned WIDTH  = 24
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_sync,
    input  logic [2*WIDTH-1:0] i_data,
    input  logic               i_flush,
    output logic               o_core_ce,
    output logic               o_core_reset,
    output logic [2*WIDTH-1:0] o_core_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_first,
    output logic               o_last,
    output logic               o_err,
    output logic [1:0]         o_state
);

    localparam logic [LGSIZE-1:0] FcntLast = {LGSIZE{1'b1}};

    state_e            r_state;
    state_e            w_state_next;
    logic [LGSIZE-1:0] r_fcnt;
    logic              r_core_reset;
    logic              r_valid;
    logic              r_first;
    logic              r_last;
    logic              r_err;

    logic              w_fcnt_zero;
    logic              w_fcnt_last;
    logic              w_adv;
    logic              w_ready;
    logic              w_take;
    logic              w_ce;
    logic              w_sync_err;
    logic              w_zero_data;
    logic              w_enter_idle;
    logic              w_out_ce;

    assign w_fcnt_zero = (r_fcnt == '0);
    assign w_fcnt_last = (r_fcnt == FcntLast);
    // Output slot is free, or its sample leaves this cycle.
    assign w_adv       = !r_valid || i_ready;
    assign w_take      = i_valid && w_ready;

    // State register.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a sync error wins over a pending flush.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_ce) begin
                    w_state_next = StFill;
                end
            end
            StFill: begin
                if (w_sync_err) begin
                    w_state_next = StIdle;
                end else if (w_ce && w_fcnt_last) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_sync_err) begin
                    w_state_next = StIdle;
                end else if (w_fcnt_zero && i_flush && w_adv) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_ce && w_fcnt_last) begin
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    // Upstream ready per state; a flush stalls input only at a frame boundary.
    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            StIdle:  w_ready = !r_core_reset;
            StFill:  w_ready = 1'b1;
            StRun:   w_ready = w_adv && !(i_flush && w_fcnt_zero);
            StDrain: w_ready = 1'b0;
        endcase
    end

    // Core strobe, data select and sync check per state.
    always_comb begin
        w_ce        = 1'b0;
        w_sync_err  = 1'b0;
        w_zero_data = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Non-sync samples are taken and dropped until a frame starts.
                w_ce = w_take && i_sync;
            end
            StFill, StRun: begin
                w_sync_err = w_take && (i_sync != w_fcnt_zero);
                w_ce       = w_take && !w_sync_err;
            end
            StDrain: begin
                w_ce        = w_adv;
                w_zero_data = 1'b1;
            end
        endcase
    end

    assign w_enter_idle = (w_state_next == StIdle) && (r_state != StIdle);
    assign w_out_ce     = w_ce && ((r_state == StRun) || (r_state == StDrain));

    // Write index counter and one-shot core reset on every return to idle.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_fcnt       <= '0;
            r_core_reset <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            r_core_reset <= w_enter_idle;
            r_err        <= w_sync_err;
            if (w_enter_idle) begin
                r_fcnt <= '0;
            end else if (w_ce) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Output tags track the core's o_out, which only moves on ce.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_sync_err) begin
            r_valid <= 1'b0;
        end else if (w_out_ce) begin
            r_valid <= 1'b1;
            r_first <= w_fcnt_zero;
            r_last  <= w_fcnt_last;
        end else begin
            r_valid <= r_valid && !i_ready;
        end
    end

    assign o_ready      = w_ready;
    assign o_core_ce    = w_ce;
    assign o_core_reset = r_core_reset;
    assign o_core_data  = w_zero_data ? '0 : i_data;
    assign o_valid      = r_valid;
    assign o_first      = r_first;
    assign o_last       = r_last;
    assign o_err        = r_err;
    assign o_state      = r_state;

endmodule
